// File: rtl/byte_to_word_packer.sv
// -----------------------------------------------------------------------------
// byte_to_word_packer
//
// Feeds the 32-bit D register stage. It packs a byte stream, little-endian,
// into words of LANES bytes. in_last flushes a partial word early, and the
// unfilled upper lanes of that word read as zero. Each finished word sits in a
// one-deep output slot until the consumer takes it. When the slot drains and a
// new word completes in the same cycle, the new word replaces the old one with
// no bubble.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    byte to pack
//   in_valid   in_data / in_last valid this cycle
//   in_last    this byte ends the current word (flush)
//   in_ready   packer can accept a byte this cycle (0 while in reset)
//   out_data   packed word, byte 0 in bits [BYTE_W-1:0]
//   out_bytes  number of valid bytes in out_data (1..LANES), 0 when idle
//   out_valid  out_data holds an undelivered word
//   out_ready  consumer takes the word this cycle
// -----------------------------------------------------------------------------
module byte_to_word_packer #(
  parameter int BYTE_W = 8,
  parameter int LANES  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BYTE_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [BYTE_W*LANES-1:0]     out_data,
  output logic [$clog2(LANES+1)-1:0]  out_bytes,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int W  = BYTE_W * LANES;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BW = $clog2(LANES + 1);

  logic [W-1:0]  r_acc;        // assembly buffer; lanes at and above r_cnt are zero
  logic [CW-1:0] r_cnt;        // index of the next lane to fill
  logic [W-1:0]  r_out_data;
  logic [BW-1:0] r_out_bytes;
  logic          r_out_valid;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_complete;
  logic [W-1:0]  w_merged;     // r_acc with the incoming byte dropped into lane r_cnt

  // in_ready depends only on reset and the output slot, never on in_valid.
  // The slot can take a new word when it is empty or is draining this cycle.
  assign w_in_ready = rst_n & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_complete = w_accept & ((r_cnt == CW'(LANES - 1)) | in_last);

  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // update; a path that leaves it unassigned would infer a latch.
    w_merged = r_acc;
    for (int l = 0; l < LANES; l++) begin
      if (r_cnt == CW'(l)) begin
        w_merged[l*BYTE_W +: BYTE_W] = in_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          // The lanes above r_cnt are already zero in r_acc, so a flushed
          // partial word comes out zero-padded without extra masking.
          r_out_data  <= w_merged;
          r_out_bytes <= BW'(r_cnt) + BW'(1);
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_merged;
          r_cnt <= r_cnt + CW'(1);
        end
      end
      // A drain empties the slot unless a new word lands in it at this edge.
      // out_data keeps its last value.
      if (r_out_valid && out_ready && !w_complete) begin
        r_out_valid <= 1'b0;
        r_out_bytes <= '0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_bytes = r_out_bytes;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_byte_to_word_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_to_word_packer
//
// Directed scenarios, then a randomized run. A reference model checks every
// cycle. The model keeps the partial word as a queue of bytes. It builds each
// finished word from that queue with plain arithmetic, and it tracks the
// output slot as valid/data/byte-count.
// -----------------------------------------------------------------------------
module tb_byte_to_word_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  m_part[$];
  logic        m_valid;
  logic [31:0] m_data;
  logic [2:0]  m_bytes;

  byte_to_word_packer #(.BYTE_W(8), .LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Inputs are driven on the falling edge. Outputs and
  // in_ready are checked against the model 1 time unit later. The model
  // advances at the rising edge.
  task automatic cycle(input logic rst, input logic v, input logic [7:0] d,
                       input logic l, input logic r);
    logic        exp_ready;
    logic        acc;
    logic        comp;
    logic [31:0] w;
    @(negedge clk);
    rst_n     = rst;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    exp_ready = rst && (!m_valid || r);
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_bytes", {29'b0, out_bytes}, {29'b0, m_bytes});
    check("out_data",  out_data, m_data);
    check("in_ready",  {31'b0, in_ready}, {31'b0, exp_ready});
    @(posedge clk);
    if (!rst) begin
      m_part.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_bytes = '0;
    end else begin
      acc  = v && exp_ready;
      comp = acc && (l || m_part.size() == 3);
      if (acc) m_part.push_back(d);
      if (comp) begin
        w = '0;
        foreach (m_part[i]) w |= 32'(m_part[i]) << (8 * i);
        m_data  = w;
        m_bytes = 3'(m_part.size());
        m_valid = 1'b1;
        m_part.delete();
      end else if (m_valid && r) begin
        m_valid = 1'b0;
        m_bytes = '0;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    cycle(1'b1, 1'b1, d, l, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    m_valid   = 1'b0;
    m_data    = '0;
    m_bytes   = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_bytes", {29'b0, out_bytes}, 32'd0);
    check("rst_out_data",  out_data, 32'h0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd0);

    // full word, one-cycle valid pulse
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    #1;
    check("w1_data",  out_data, 32'h44332211);
    check("w1_bytes", {29'b0, out_bytes}, 32'd4);
    check("w1_valid", {31'b0, out_valid}, 32'd1);
    idle();
    #1;
    check("w1_pulse_end", {31'b0, out_valid}, 32'd0);

    // early flush of a 3-byte word
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
    #1;
    check("flush_data",  out_data, 32'h00CCBBAA);
    check("flush_bytes", {29'b0, out_bytes}, 32'd3);

    // back-to-back words, the next starting at lane 0
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0);
      if (i == 4) begin
        #1;
        check("b2b_w0", out_data, 32'h04030201);
      end
    end
    #1;
    check("b2b_w1", out_data, 32'h08070605);
    check("b2b_w1_bytes", {29'b0, out_bytes}, 32'd4);
    idle();

    // backpressure: word held for 5 cycles, offered bytes refused
    send(8'hEF, 1'b0); send(8'hBE, 1'b0); send(8'hAD, 1'b0);
    cycle(1'b1, 1'b1, 8'hDE, 1'b0, 1'b0);
    #1;
    check("bp_data", out_data, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    #1;
    check("bp_hold_data",  out_data, 32'hDEADBEEF);
    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    check("bp_in_ready",   {31'b0, in_ready}, 32'd0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    check("bp_drained",  {31'b0, out_valid}, 32'd0);
    check("bp_data_kept", out_data, 32'hDEADBEEF);

    // reset mid-word discards partial bytes
    send(8'h55, 1'b0); send(8'h66, 1'b0);
    cycle(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_data",  out_data, 32'h0);
    send(8'h77, 1'b0); send(8'h88, 1'b0); send(8'h99, 1'b0); send(8'hAA, 1'b0);
    #1;
    check("post_rst_word",  out_data, 32'hAA998877);
    check("post_rst_bytes", {29'b0, out_bytes}, 32'd4);
    idle();

    // single-byte flush at lane 0
    send(8'h5A, 1'b1);
    #1;
    check("single_data",  out_data, 32'h0000005A);
    check("single_bytes", {29'b0, out_bytes}, 32'd1);
    idle();

    // randomized traffic with backpressure, flushes and occasional reset
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) != 0),
            8'($urandom),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) != 0));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
